// File: rtl/vliw_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : vliw_ctrl_stage
// Description : Registered decode-control stage for the VLIW pipeline.
//               Decodes NUM_SLOTS instruction slots per bundle into per-slot
//               control words. The words are held in an ID/EX output register
//               behind a valid/ready handshake. After the first jump in a
//               bundle, the later slots are squashed. After a jump issues, a
//               fetch-flush window drops FLUSH_CYCLES accepted bundles. A
//               bundle with a surviving illegal encoding traps the stage.
// Ports       : clk, rst (sync, active-high)
//               in_valid/in_ready       - bundle input handshake
//               slot_valid/opcode/funct3 - per-slot instruction fields
//               flush_in                - backend redirect (kills everything)
//               trap_clr                - leave TRAP
//               out_valid/out_ready     - ID/EX register handshake
//               out_slot_valid, pc_in, reg_write, jump, mem_write,
//               mem_to_reg, slti, illegal, alu_op, alu_src_b - control words
//               if_flush                - one-cycle pulse with a jump bundle
//               trapped                 - high while in TRAP
// Revision    : 1.0 - initial release
// ============================================================================
module vliw_ctrl_stage #(
    parameter int NUM_SLOTS    = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SLOTS-1:0]     slot_valid,
    input  logic [7*NUM_SLOTS-1:0]   opcode,
    input  logic [3*NUM_SLOTS-1:0]   funct3,
    input  logic                     flush_in,
    input  logic                     trap_clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_SLOTS-1:0]     out_slot_valid,
    output logic [2*NUM_SLOTS-1:0]   pc_in,
    output logic [NUM_SLOTS-1:0]     reg_write,
    output logic [NUM_SLOTS-1:0]     jump,
    output logic [NUM_SLOTS-1:0]     mem_write,
    output logic [NUM_SLOTS-1:0]     mem_to_reg,
    output logic [NUM_SLOTS-1:0]     slti,
    output logic [NUM_SLOTS-1:0]     illegal,
    output logic [2*NUM_SLOTS-1:0]   alu_op,
    output logic [3*NUM_SLOTS-1:0]   alu_src_b,
    output logic                     if_flush,
    output logic                     trapped
);

    localparam logic [1:0] c_RUN        = 2'd0;
    localparam logic [1:0] c_FLUSH      = 2'd1;
    localparam logic [1:0] c_TRAP       = 2'd2;
    localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES);

    // ---------------- combinational bundle decode ----------------
    logic [NUM_SLOTS-1:0]   w_slot_valid, w_reg_write, w_jump, w_mem_write;
    logic [NUM_SLOTS-1:0]   w_mem_to_reg, w_slti, w_illegal;
    logic [2*NUM_SLOTS-1:0] w_pc_in, w_alu_op;
    logic [3*NUM_SLOTS-1:0] w_alu_src_b;
    logic                   w_squash;
    logic [9:0]             w_enc;

    always_comb begin
        w_slot_valid = '0;
        w_reg_write  = '0;
        w_jump       = '0;
        w_mem_write  = '0;
        w_mem_to_reg = '0;
        w_slti       = '0;
        w_illegal    = '0;
        w_pc_in      = '0;
        w_alu_op     = '0;
        w_alu_src_b  = '0;
        w_squash     = 1'b0;
        w_enc        = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            // Slots past the first jump stay fully zero, so they can never
            // report illegal.
            if (slot_valid[k] && !w_squash) begin
                w_slot_valid[k] = 1'b1;
                w_enc = {opcode[7*k +: 7], funct3[3*k +: 3]};
                case (w_enc)
                    10'b0010011_000: begin
                        w_reg_write[k]     = 1'b1;
                        w_alu_src_b[3*k +: 3] = 3'b010;
                    end
                    10'b0010011_010: begin
                        w_reg_write[k]     = 1'b1;
                        w_alu_op[2*k +: 2] = 2'b11;
                        w_alu_src_b[3*k +: 3] = 3'b010;
                        w_slti[k]          = 1'b1;
                    end
                    10'b0010011_101: begin
                        w_reg_write[k]     = 1'b1;
                        w_alu_op[2*k +: 2] = 2'b10;
                        w_alu_src_b[3*k +: 3] = 3'b001;
                    end
                    10'b0110011_100: begin
                        w_reg_write[k]     = 1'b1;
                        w_alu_op[2*k +: 2] = 2'b01;
                    end
                    10'b1100111_000: begin
                        w_pc_in[2*k +: 2]  = 2'b10;
                        w_reg_write[k]     = 1'b1;
                        w_jump[k]          = 1'b1;
                        w_mem_to_reg[k]    = 1'b1;
                        w_alu_src_b[3*k +: 3] = 3'b100;
                        w_squash           = 1'b1;
                    end
                    10'b0100011_010: begin
                        w_mem_write[k]     = 1'b1;
                        w_alu_src_b[3*k +: 3] = 3'b011;
                    end
                    default: w_illegal[k] = 1'b1;
                endcase
            end
        end
    end

    // ---------------- state and output registers ----------------
    logic [1:0]             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic                   if_flush_q, if_flush_d;
    logic [NUM_SLOTS-1:0]   out_slot_valid_q, out_slot_valid_d;
    logic [NUM_SLOTS-1:0]   reg_write_q, reg_write_d, jump_q, jump_d;
    logic [NUM_SLOTS-1:0]   mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
    logic [NUM_SLOTS-1:0]   slti_q, slti_d, illegal_q, illegal_d;
    logic [2*NUM_SLOTS-1:0] pc_in_q, pc_in_d, alu_op_q, alu_op_d;
    logic [3*NUM_SLOTS-1:0] alu_src_b_q, alu_src_b_d;

    logic w_accept;
    logic w_load;
    logic w_has_jump;
    logic w_has_illegal;

    // A redirect this cycle blocks acceptance so the offered bundle is not lost
    // into a stage that is being cleared.
    assign in_ready      = (state_q != c_TRAP) && (!out_valid_q || out_ready) && !flush_in;
    assign w_accept      = in_valid && in_ready;
    assign w_load        = w_accept && (state_q == c_RUN);
    assign w_has_jump    = |w_jump;
    assign w_has_illegal = |w_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= c_RUN;
            cnt_q            <= '0;
            out_valid_q      <= 1'b0;
            if_flush_q       <= 1'b0;
            out_slot_valid_q <= '0;
            reg_write_q      <= '0;
            jump_q           <= '0;
            mem_write_q      <= '0;
            mem_to_reg_q     <= '0;
            slti_q           <= '0;
            illegal_q        <= '0;
            pc_in_q          <= '0;
            alu_op_q         <= '0;
            alu_src_b_q      <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            out_valid_q      <= out_valid_d;
            if_flush_q       <= if_flush_d;
            out_slot_valid_q <= out_slot_valid_d;
            reg_write_q      <= reg_write_d;
            jump_q           <= jump_d;
            mem_write_q      <= mem_write_d;
            mem_to_reg_q     <= mem_to_reg_d;
            slti_q           <= slti_d;
            illegal_q        <= illegal_d;
            pc_in_q          <= pc_in_d;
            alu_op_q         <= alu_op_d;
            alu_src_b_q      <= alu_src_b_d;
        end
    end

    // Next-state logic. A trap takes precedence over opening a flush window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_in) begin
            state_d = c_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                c_RUN: begin
                    if (w_accept) begin
                        if (w_has_illegal) begin
                            state_d = c_TRAP;
                        end else if (w_has_jump && (c_FLUSH_LOAD != 4'd0)) begin
                            state_d = c_FLUSH;
                            cnt_d   = c_FLUSH_LOAD;
                        end
                    end
                end
                c_FLUSH: begin
                    if (w_accept) begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_d = c_RUN;
                        end
                    end
                end
                c_TRAP: begin
                    if (trap_clr) begin
                        state_d = c_RUN;
                    end
                end
                default: state_d = c_RUN;
            endcase
        end
    end

    // Output register next values. if_flush defaults low so it only spans the
    // first output cycle of a jump bundle, even if that bundle then stalls.
    always_comb begin
        out_valid_d      = out_valid_q;
        if_flush_d       = 1'b0;
        out_slot_valid_d = out_slot_valid_q;
        reg_write_d      = reg_write_q;
        jump_d           = jump_q;
        mem_write_d      = mem_write_q;
        mem_to_reg_d     = mem_to_reg_q;
        slti_d           = slti_q;
        illegal_d        = illegal_q;
        pc_in_d          = pc_in_q;
        alu_op_d         = alu_op_q;
        alu_src_b_d      = alu_src_b_q;
        if (flush_in) begin
            out_valid_d = 1'b0;
        end else if (w_load) begin
            out_valid_d      = 1'b1;
            if_flush_d       = w_has_jump;
            out_slot_valid_d = w_slot_valid;
            reg_write_d      = w_reg_write;
            jump_d           = w_jump;
            mem_write_d      = w_mem_write;
            mem_to_reg_d     = w_mem_to_reg;
            slti_d           = w_slti;
            illegal_d        = w_illegal;
            pc_in_d          = w_pc_in;
            alu_op_d         = w_alu_op;
            alu_src_b_d      = w_alu_src_b;
        end else if (out_ready) begin
            // Consumed with nothing new loaded (includes discarded bundles).
            out_valid_d = 1'b0;
        end
    end

    assign out_valid      = out_valid_q;
    assign if_flush       = if_flush_q;
    assign trapped        = (state_q == c_TRAP);
    assign out_slot_valid = out_slot_valid_q;
    assign reg_write      = reg_write_q;
    assign jump           = jump_q;
    assign mem_write      = mem_write_q;
    assign mem_to_reg     = mem_to_reg_q;
    assign slti           = slti_q;
    assign illegal        = illegal_q;
    assign pc_in          = pc_in_q;
    assign alu_op         = alu_op_q;
    assign alu_src_b      = alu_src_b_q;

endmodule
`default_nettype wire

// File: doc/vliw_ctrl_stage.md
Name: vliw_ctrl_stage

Overview:
- Parametrised, registered decode-control stage for the VLIW pipeline.
- Decodes NUM_SLOTS instruction slots per bundle into per-slot control words and holds them in an ID/EX output register with a valid/ready handshake.
- Adds behaviour earlier control decoders lack:
  - default/illegal decoding;
  - intra-bundle squash after a jump;
  - a multi-cycle fetch-flush window;
  - a trap state on illegal encodings.

Parameters:
- NUM_SLOTS, 2: instruction slots per bundle (1..4).
- FLUSH_CYCLES, 2: accepted bundles discarded after a jump issues (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  bundle present
- in_ready  out  1  stage accepts bundle this cycle
- slot_valid  in  NUM_SLOTS  per-slot occupancy; bit k = slot k
- opcode  in  7*NUM_SLOTS  slot k at [7k+6:7k]
- funct3  in  3*NUM_SLOTS  slot k at [3k+2:3k]
- flush_in  in  1  backend redirect; kills held bundle and flush window
- trap_clr  in  1  leave TRAP
- out_valid  out  1  registered bundle valid
- out_ready  in  1  downstream consumes
- out_slot_valid  out  NUM_SLOTS  per-slot valid after squash
- pc_in  out  2*NUM_SLOTS
- reg_write, jump, mem_write, mem_to_reg, slti, illegal  out  NUM_SLOTS each
- alu_op  out  2*NUM_SLOTS
- alu_src_b  out  3*NUM_SLOTS
- if_flush  out  1  one-cycle pulse, registered with the jump bundle
- trapped  out  1  high while in TRAP

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high.
- Reset: all outputs 0; state RUN; flush counter 0.
- Decode table, per slot. All fields not listed are 0.
  - opcode 0010011, funct3 000 (addi): reg_write=1, alu_op=00, alu_src_b=010.
  - opcode 0010011, funct3 010 (slti): reg_write=1, alu_op=11, alu_src_b=010, slti=1.
  - opcode 0010011, funct3 101 (srli): reg_write=1, alu_op=10, alu_src_b=001.
  - opcode 0110011, funct3 100 (xor): reg_write=1, alu_op=01, alu_src_b=000.
  - opcode 1100111, funct3 000 (jalr): pc_in=10, reg_write=1, jump=1, mem_to_reg=1, alu_src_b=100.
  - opcode 0100011, funct3 010 (sw): mem_write=1, alu_src_b=011.
  - Any other encoding in a valid slot: illegal=1, all other fields 0.
  - Invalid slot: all fields 0, including illegal.
- Handshake:
  - in_ready = (state != TRAP) && (!out_valid || out_ready).
  - A bundle is accepted when in_valid && in_ready.
  - Latency: 1 cycle from acceptance to out_valid.
  - Output holds stable while out_valid && !out_ready.
  - out_valid drops when the bundle is consumed and no new bundle loads.
- Squash within a bundle:
  - The lowest-index valid slot with jump=1 is the jump slot.
  - Every higher slot has out_slot_valid=0 and all its fields zeroed.
  - Squashed slots never raise illegal.
- State machine: RUN, FLUSH, TRAP.
  - RUN, accepting a bundle containing a surviving jump: load bundle, set if_flush=1 for its output cycle.
    - If FLUSH_CYCLES > 0: go to FLUSH with counter = FLUSH_CYCLES.
  - FLUSH: each accepted bundle is discarded (not loaded) and the counter decrements. Return to RUN when the counter reaches 0.
    - FLUSH_CYCLES=0: FLUSH is never entered.
  - RUN, accepting a bundle with a surviving illegal slot: load it normally, then go to TRAP.
    - A jump in the same bundle before the illegal slot squashes it, so no trap occurs.
    - An illegal slot before the jump gives TRAP, with if_flush still pulsed.
  - TRAP: in_ready=0 and trapped=1. trap_clr returns to RUN.
- flush_in:
  - Priority over everything except rst.
  - Clears out_valid, if_flush and the counter; state goes to RUN, including from TRAP.
  - A bundle offered the same cycle is not accepted: in_ready is forced 0 that cycle.
- if_flush is high only in the first cycle out_valid is high for the jump bundle, even while stalled.
- Reset asserted mid-flush or mid-stall: all state cleared next edge.

Test Plan:
1. NUM_SLOTS=2. Slot0 addi (0010011/000), slot1 xor (0110011/100), out_ready=1 → next cycle out_valid=1, reg_write=11, alu_op={01,00}, alu_src_b={000,010}.
2. Slot0 jalr, slot1 sw → out_slot_valid=01, mem_write=00, pc_in[1:0]=10, if_flush=1 for one cycle. The next 2 accepted bundles are dropped (out_valid=0); the 3rd appears.
3. Slot1 opcode 1111111 → illegal=10 with that bundle; trapped=1; in_ready=0 until trap_clr pulse, then 1.
4. Valid slti bundle with out_ready=0 for 3 cycles → outputs stable, in_ready=0, slti=01 and alu_op[1:0]=11 until consumed.
5. flush_in during FLUSH with counter=1 and a bundle held → out_valid=0, state RUN, next offered bundle accepted and output.
6. rst asserted during TRAP with a stalled bundle → all outputs 0 and in_ready=1 the following cycle.
